// File: rtl/rv32_ifetch_queue.sv
// RV32 instruction fetch queue: issues sequential word reads under a credit
// limit, queues returned instructions with their PCs, and drops stale returns after a redirect.
module rv32_ifetch_queue #(
  parameter int          DEPTH        = 4,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic [31:0]              flush_pc,
  output logic                     instr_valid,
  output logic [31:0]              instr,
  output logic [31:0]              instr_pc,
  input  logic                     instr_ready,
  output logic [31:0]              iaddress,
  output logic                     iread,
  input  logic                     iwaitrequest,
  input  logic [31:0]              ireaddata,
  input  logic                     ireaddatavalid,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   fpc;
  logic [31:0]   rpc;
  logic [AW:0]   outstanding;
  logic [AW:0]   drop_cnt;
  logic [AW:0]   count;
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [31:0]   q_instr [DEPTH];
  logic [31:0]   q_pc    [DEPTH];

  logic [AW+1:0] credit_used;
  logic          accept;
  logic          push;
  logic          pop;
  logic          drop_ret;
  logic [31:0]   flush_target;

  // Queued entries plus reads in flight may never exceed DEPTH, so a return
  // always finds a free slot.
  assign credit_used  = {1'b0, count} + {1'b0, outstanding};
  assign iread        = ~reset & ~flush & (credit_used < (AW+2)'(DEPTH));
  assign accept       = iread & ~iwaitrequest;
  assign drop_ret     = ireaddatavalid & (drop_cnt != '0);
  assign push         = ireaddatavalid & (drop_cnt == '0) & ~flush;
  assign pop          = instr_valid & instr_ready & ~flush;
  assign flush_target = flush_pc & ~32'h3;

  assign iaddress    = fpc;
  assign level       = count;
  assign instr_valid = (count != '0);
  assign instr       = instr_valid ? q_instr[head] : '0;
  assign instr_pc    = instr_valid ? q_pc[head]    : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fpc         <= RESET_VECTOR;
      rpc         <= RESET_VECTOR;
      outstanding <= '0;
      drop_cnt    <= '0;
      count       <= '0;
      head        <= '0;
      tail        <= '0;
    end else begin
      // accept is never set during flush, so this covers both paths.
      outstanding <= outstanding + (AW+1)'(accept) - (AW+1)'(ireaddatavalid);
      if (flush) begin
        fpc      <= flush_target;
        rpc      <= flush_target;
        drop_cnt <= outstanding - (AW+1)'(ireaddatavalid);
        count    <= '0;
        head     <= tail;
      end else begin
        if (accept)
          fpc <= fpc + 32'd4;
        if (drop_ret)
          drop_cnt <= drop_cnt - 1'b1;
        if (push) begin
          rpc  <= rpc + 32'd4;
          tail <= tail + 1'b1;
        end
        if (pop)
          head <= head + 1'b1;
        count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_instr[tail] <= ireaddata;
      q_pc[tail]    <= rpc;
    end
  end

endmodule
